dac_spi_rx: RTL and testbench

- Receiver end of the 24-bit DAC serial link: oversamples SYNC/SCLK/DIN on the system clock and shifts in each frame.
- Frame format: 4-bit command, 4-bit address, 16-bit data, MSB first.
- Decodes each frame into a 16-channel input/output register bank.
- Serves as the on-board DAC emulator and loopback checker for the DAC SPI transmitter.

---
 rtl/dac_spi_pkg.sv | 19 +
 rtl/dac_spi_rx_sync.sv | 35 +++
 rtl/dac_spi_rx.sv | 147 ++++++++++++++
 tb/tb_dac_spi_rx.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/dac_spi_pkg.sv
// Shared definitions for the 24-bit DAC serial link (transmitter and receiver).
`timescale 1ns/1ps
package dac_spi_pkg;
  localparam logic [3:0] CMD_WR_IN      = 4'h0;
  localparam logic [3:0] CMD_UPD        = 4'h1;
  localparam logic [3:0] CMD_WR_UPD_ALL = 4'h2;
  localparam logic [3:0] CMD_WR_UPD     = 4'h3;

  localparam int DAC_FRAME_BITS = 24;
  localparam int COMM_MSB       = 23;
  localparam int ADDR_MSB       = 19;
  localparam int DATA_MSB       = 15;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } rx_state_e;
endpackage

// File: rtl/dac_spi_rx_sync.sv
// N-stage input synchronizer with a chosen reset value and a registered edge detect.
`timescale 1ns/1ps
module spi_in_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
);
  logic [STAGES-1:0] sync_q, sync_d;
  logic              prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], din};
    prev_d = sync_q[STAGES-1];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign dout = sync_q[STAGES-1];
  assign rise = dout & ~prev_q;
  assign fall = ~dout & prev_q;
endmodule

// File: rtl/dac_spi_rx.sv
// DAC serial-link receiver: oversamples SYNC/SCLK/DIN, shifts in 24-bit frames and
// applies each good frame to a bank of input/output channel registers.
`timescale 1ns/1ps
module dac_spi_rx
  import dac_spi_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int NBITS       = 24,
  parameter int NCH         = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        spi_sync,
  input  logic        spi_sclk,
  input  logic        spi_data,
  input  logic [3:0]  rd_addr,
  output logic [15:0] rd_data,
  output logic        rx_valid,
  output logic [3:0]  rx_comm,
  output logic [3:0]  rx_addr,
  output logic [15:0] rx_data,
  output logic        frame_err,
  output logic        busy
);
  logic sync_s, sync_rise, sync_fall;
  logic sclk_s, sclk_rise, sclk_fall;
  logic data_s, data_rise, data_fall;
  logic unused_edges;

  // Reset values chosen so that no edge is reported right after reset.
  spi_in_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_sync (
    .clk(clk), .rst(rst), .din(spi_sync), .dout(sync_s), .rise(sync_rise), .fall(sync_fall));
  spi_in_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sclk_sync (
    .clk(clk), .rst(rst), .din(spi_sclk), .dout(sclk_s), .rise(sclk_rise), .fall(sclk_fall));
  spi_in_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_data_sync (
    .clk(clk), .rst(rst), .din(spi_data), .dout(data_s), .rise(data_rise), .fall(data_fall));

  assign unused_edges = ^{sync_s, sclk_s, sclk_rise, data_rise, data_fall};

  rx_state_e                 state_q, state_d;
  logic [DAC_FRAME_BITS-1:0] sr_q, sr_d;
  logic [4:0]                cnt_q, cnt_d;
  logic                      rx_valid_q, rx_valid_d;
  logic                      frame_err_q, frame_err_d;
  logic [3:0]                rx_comm_q, rx_comm_d;
  logic [3:0]                rx_addr_q, rx_addr_d;
  logic [15:0]               rx_data_q, rx_data_d;
  logic [15:0]               in_q [NCH];
  logic [15:0]               in_d [NCH];
  logic [15:0]               out_q [NCH];
  logic [15:0]               out_d [NCH];
  logic [3:0]                f_comm, f_addr;
  logic [15:0]               f_data;

  assign f_comm = sr_q[COMM_MSB -: 4];
  assign f_addr = sr_q[ADDR_MSB -: 4];
  assign f_data = sr_q[DATA_MSB -: 16];

  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    cnt_d       = cnt_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;
    rx_comm_d   = rx_comm_q;
    rx_addr_d   = rx_addr_q;
    rx_data_d   = rx_data_q;
    in_d        = in_q;
    out_d       = out_q;
    case (state_q)
      ST_IDLE: begin
        if (sync_fall) begin
          state_d = ST_SHIFT;
          sr_d    = '0;
          cnt_d   = '0;
        end
      end
      ST_SHIFT: begin
        // A final SCLK fall coinciding with SYNC rise still counts as a bit.
        if (sclk_fall) begin
          sr_d = {sr_q[DAC_FRAME_BITS-2:0], data_s};
          if (cnt_q != 5'd31) cnt_d = cnt_q + 5'd1;
        end
        if (sync_rise) state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        if (cnt_q == 5'(NBITS)) begin
          rx_valid_d = 1'b1;
          rx_comm_d  = f_comm;
          rx_addr_d  = f_addr;
          rx_data_d  = f_data;
          case (f_comm)
            CMD_WR_IN: in_d[f_addr] = f_data;
            CMD_UPD:   out_d[f_addr] = in_q[f_addr];
            CMD_WR_UPD_ALL: begin
              in_d[f_addr] = f_data;
              for (int i = 0; i < NCH; i++) out_d[i] = in_d[i];
            end
            CMD_WR_UPD: begin
              in_d[f_addr]  = f_data;
              out_d[f_addr] = f_data;
            end
            default: ;
          endcase
        end else begin
          frame_err_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      sr_q        <= '0;
      cnt_q       <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      rx_comm_q   <= '0;
      rx_addr_q   <= '0;
      rx_data_q   <= '0;
      in_q        <= '{default: '0};
      out_q       <= '{default: '0};
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      cnt_q       <= cnt_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      rx_comm_q   <= rx_comm_d;
      rx_addr_q   <= rx_addr_d;
      rx_data_q   <= rx_data_d;
      in_q        <= in_d;
      out_q       <= out_d;
    end
  end

  assign rd_data   = out_q[rd_addr];
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign rx_comm   = rx_comm_q;
  assign rx_addr   = rx_addr_q;
  assign rx_data   = rx_data_q;
  assign busy      = (state_q == ST_SHIFT);
endmodule

// File: tb/tb_dac_spi_rx.sv
// Directed frames into dac_spi_rx; expected frames are queued and checked by a monitor.
`timescale 1ns/1ps
module tb_dac_spi_rx;
  logic        clk = 1'b0;
  logic        rst;
  logic        spi_sync, spi_sclk, spi_data;
  logic [3:0]  rd_addr;
  logic [15:0] rd_data;
  logic        rx_valid, frame_err, busy;
  logic [3:0]  rx_comm, rx_addr;
  logic [15:0] rx_data;

  always #5 clk = ~clk;

  dac_spi_rx dut (
    .clk(clk), .rst(rst), .spi_sync(spi_sync), .spi_sclk(spi_sclk), .spi_data(spi_data),
    .rd_addr(rd_addr), .rd_data(rd_data), .rx_valid(rx_valid), .rx_comm(rx_comm),
    .rx_addr(rx_addr), .rx_data(rx_data), .frame_err(frame_err), .busy(busy));

  int          tests = 0;
  int          fails = 0;
  int          valid_seen = 0;
  int          err_seen = 0;
  logic [23:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rx_valid === 1'b1) begin
      valid_seen++;
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL rx_valid unexpected: got frame 0x%0h, expected none", {rx_comm, rx_addr, rx_data});
      end else begin
        chk("rx frame", {8'h0, rx_comm, rx_addr, rx_data}, {8'h0, exp_q.pop_front()});
      end
    end
    if (frame_err === 1'b1) err_seen++;
  end

  // Data changes with SCLK rising and is held through the falling (sampling) edge.
  task automatic send(input logic [23:0] w, input int nbits, input bit close);
    spi_sync = 1'b0;
    #200;
    for (int i = nbits - 1; i >= 0; i--) begin
      spi_data = (i < 24) ? w[i] : 1'b0;
      #160 spi_sclk = 1'b0;
      #160 spi_sclk = 1'b1;
    end
    if (close) begin
      #160 spi_sync = 1'b1;
      spi_data = 1'b0;
      repeat (12) @(posedge clk);
      #3;
    end
  endtask

  task automatic frame(input logic [3:0] c, input logic [3:0] a, input logic [15:0] d);
    exp_q.push_back({c, a, d});
    send({c, a, d}, 24, 1'b1);
    chk("frame consumed", exp_q.size(), 0);
  endtask

  task automatic rd(input logic [3:0] a, input logic [15:0] e);
    rd_addr = a;
    #1;
    chk($sformatf("rd_data ch%0d", a), {16'h0, rd_data}, {16'h0, e});
  endtask

  initial begin
    rst = 1'b0;
    spi_sync = 1'b1;
    spi_sclk = 1'b1;
    spi_data = 1'b0;
    rd_addr = 4'h0;
    #23 rst = 1'b1;
    repeat (5) @(posedge clk);
    #3;

    chk("reset busy", {31'h0, busy}, 0);
    chk("reset rx_valid", {31'h0, rx_valid}, 0);
    chk("reset frame_err", {31'h0, frame_err}, 0);
    chk("reset rx fields", {8'h0, rx_comm, rx_addr, rx_data}, 0);
    for (int i = 0; i < 16; i++) rd(4'(i), 16'h0000);

    frame(4'h3, 4'h5, 16'hA5C3);
    rd(4'h5, 16'hA5C3);
    rd(4'h4, 16'h0000);
    rd(4'h6, 16'h0000);

    frame(4'h0, 4'h2, 16'h1234);
    rd(4'h2, 16'h0000);
    frame(4'h1, 4'h2, 16'h0000);
    rd(4'h2, 16'h1234);

    send(24'hF0ABCD, 23, 1'b1);
    send(24'h3E5555, 25, 1'b1);
    chk("frame_err count", err_seen, 2);
    chk("rx fields after bad frames", {8'h0, rx_comm, rx_addr, rx_data}, 32'h0012_0000);
    rd(4'h2, 16'h1234);
    rd(4'hE, 16'h0000);

    frame(4'h0, 4'h0, 16'h1111);
    frame(4'h0, 4'hF, 16'hFFFF);
    rd(4'h0, 16'h0000);
    frame(4'h2, 4'h7, 16'h7777);
    rd(4'h0, 16'h1111);
    rd(4'h7, 16'h7777);
    rd(4'hF, 16'hFFFF);
    rd(4'h5, 16'hA5C3);
    rd(4'h2, 16'h1234);
    rd(4'h1, 16'h0000);

    send(24'h3AFACE, 12, 1'b0);
    #20;
    chk("busy mid-frame", {31'h0, busy}, 1);
    rst = 1'b0;
    #20;
    chk("busy during reset", {31'h0, busy}, 0);
    spi_sync = 1'b1;
    spi_sclk = 1'b1;
    spi_data = 1'b0;
    #50 rst = 1'b1;
    repeat (5) @(posedge clk);
    #3;
    chk("busy after reset", {31'h0, busy}, 0);
    rd(4'h5, 16'h0000);
    frame(4'h3, 4'h9, 16'hBEEF);
    rd(4'h9, 16'hBEEF);
    rd(4'hA, 16'h0000);

    chk("rx_valid pulse count", valid_seen, 7);
    chk("frame_err final count", err_seen, 2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
